// File: rtl/dadda_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined Dadda multiplier.
// The master side produces operands and consumes products; the slave side is the multiplier.
interface dadda_mult_pipe_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] op;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, op
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, op
  );
endinterface

// File: rtl/dadda_mult_pipe.sv
// WIDTH x WIDTH three-stage Dadda-tree multiplier with valid/ready on both sides.
// Signed operands use the Baugh-Wooley partial-product form, so one tree serves both modes.
module dadda_mult_pipe #(
  parameter int WIDTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  dadda_mult_pipe_if.slave bus
);
  localparam int PW   = 2 * WIDTH;
  localparam int MAXH = WIDTH;

  // Dadda height sequence 2,3,4,6,9,13,...
  function automatic int dadda_height(input int k);
    int d;
    d = 2;
    for (int i = 0; i < k; i++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int dadda_stages(input int h);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (dadda_height(i) < h) n++;
    return n;
  endfunction

  localparam int NSTG = dadda_stages(MAXH);

  logic advance;
  logic vld_p1, vld_p2, vld_p3;

  logic [WIDTH-1:0] pp_d  [WIDTH];
  logic [WIDTH-1:0] pp_p1 [WIDTH];
  logic             sgn_p1;
  logic [PW-1:0]    row_a, row_b;
  logic [PW-1:0]    row_a_p2, row_b_p2;
  logic [PW-1:0]    op_p3;

  // One global stall: every stage moves together or nothing moves.
  assign advance       = !vld_p3 || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p3;
  assign bus.op        = op_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  // ---- S1: partial-product matrix, row i = multiplier bit i ----
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_d[i][j] = bus.a[j] & bus.b[i];
        if (bus.is_signed && ((i == WIDTH-1) != (j == WIDTH-1)))
          pp_d[i][j] = !pp_d[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance && bus.in_valid) begin
      pp_p1  <= pp_d;
      sgn_p1 <= bus.is_signed;
    end
  end

  // ---- S2: Dadda column reduction down to two rows ----
  always_comb begin
    logic [MAXH-1:0] col  [PW];
    logic [MAXH-1:0] nxt  [PW];
    int              cnt  [PW];
    int              ncnt [PW];
    int              d, h, p;
    logic            x, y, z;
    col   = '{default: '0};
    nxt   = '{default: '0};
    cnt   = '{default: 0};
    ncnt  = '{default: 0};
    d     = 0;
    h     = 0;
    p     = 0;
    x     = 1'b0;
    y     = 1'b0;
    z     = 1'b0;
    row_a = '0;
    row_b = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col[i+j][cnt[i+j]] = pp_p1[i][j];
        cnt[i+j] = cnt[i+j] + 1;
      end
    end
    // Baugh-Wooley correction ones; zero in unsigned mode.
    col[WIDTH][cnt[WIDTH]] = sgn_p1;
    cnt[WIDTH] = cnt[WIDTH] + 1;
    col[PW-1][cnt[PW-1]] = sgn_p1;
    cnt[PW-1] = cnt[PW-1] + 1;

    for (int s = NSTG - 1; s >= 0; s--) begin
      d    = dadda_height(s);
      nxt  = '{default: '0};
      ncnt = '{default: 0};
      for (int c = 0; c < PW; c++) begin
        // Carries already dropped into this column count toward its new height.
        h = cnt[c] + ncnt[c];
        p = 0;
        for (int k = 0; k < MAXH; k++) begin
          if (h > d) begin
            x = col[c][p];
            y = col[c][p+1];
            if (h == d + 1) begin
              nxt[c][ncnt[c]] = x ^ y;
              ncnt[c] = ncnt[c] + 1;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = x & y;
                ncnt[c+1] = ncnt[c+1] + 1;
              end
              p = p + 2;
              h = h - 1;
            end else begin
              z = col[c][p+2];
              nxt[c][ncnt[c]] = x ^ y ^ z;
              ncnt[c] = ncnt[c] + 1;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = (x & y) | (x & z) | (y & z);
                ncnt[c+1] = ncnt[c+1] + 1;
              end
              p = p + 3;
              h = h - 2;
            end
          end
        end
        for (int k = 0; k < MAXH; k++) begin
          if (k >= p && k < cnt[c]) begin
            nxt[c][ncnt[c]] = col[c][k];
            ncnt[c] = ncnt[c] + 1;
          end
        end
      end
      col = nxt;
      cnt = ncnt;
    end

    for (int c = 0; c < PW; c++) begin
      row_a[c] = col[c][0];
      row_b[c] = col[c][1];
    end
  end

  always_ff @(posedge clk) begin
    if (advance && vld_p1) begin
      row_a_p2 <= row_a;
      row_b_p2 <= row_b;
    end
  end

  // ---- S3: carry-propagate add; carry out of the top bit is dropped ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p3 <= '0;
    end else if (advance && vld_p2) begin
      op_p3 <= row_a_p2 + row_b_p2;
    end
  end
endmodule
